// File: rtl/logic_gate_pkg.sv
// ---------------------------------------------------------------------------
// logic_gate_pkg
// Shared definitions for logic_gate_arbiter:
//   - OP_W and the op-code enum (OP_AND..OP_XNOR)
//   - result-register state constants (ST_EMPTY / ST_FULL)
//   - logic_op(): the bitwise gate function used by the datapath
// logic_op works on MAX_W bits. Callers zero-extend narrower operands and
// truncate the result. Every op is bitwise, so truncation is exact.
// ---------------------------------------------------------------------------
package logic_gate_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOTA = 3'd3,
    OP_NOTB = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  // Result-register state; the state bit is what res_valid_out shows.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic logic [MAX_W-1:0] logic_op(
    input logic [OP_W-1:0]  op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b
  );
    logic [MAX_W-1:0] r;
    r = '0;
    case (op_e'(op))
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOTA: r = ~a;
      OP_NOTB: r = ~b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// This is purely combinational round-robin search logic. The search starts at
// ptr_i+1 and wraps modulo NUM_REQ. The first asserted req_i bit wins.
// Ports:
//   req_i   [NUM_REQ] request vector
//   ptr_i   [ID_W]    index of the last winner; the search starts after it
//   en_i              gates grant_o. idx_o shows the winner even while en_i
//                     is low.
//   grant_o [NUM_REQ] one-hot grant, all-zero when no request or !en_i
//   idx_o   [ID_W]    index of the winning request; 0 when there is none
// The pointer register lives in the parent module.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o
);

  logic            found;
  int              k;
  logic [ID_W-1:0] k_idx;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = 0;
    k_idx   = '0;
    // Offsets run 1..NUM_REQ. The last candidate is ptr itself, so a lone
    // persistent requester is still picked every cycle.
    for (int i = 1; i <= NUM_REQ; i++) begin
      k     = (int'(ptr_i) + i) % NUM_REQ;
      k_idx = ID_W'(k);
      if (!found && req_i[k_idx]) begin
        found = 1'b1;
        idx_o = k_idx;
      end
    end
    if (en_i && found) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/logic_gate_arbiter.sv
// ---------------------------------------------------------------------------
// logic_gate_arbiter
// One bitwise gate unit is shared between NUM_REQ requesters. A round-robin
// grant picks one request per cycle. The result goes into a 1-entry output
// register.
// Ports:
//   clk_in, rstn_in (synchronous, active-low)
//   req_valid_in / req_ready_out [NUM_REQ], req_op_in [3*NUM_REQ],
//   req_a_in / req_b_in [WIDTH*NUM_REQ]   : request side, slice i per requester
//   res_valid_out / res_ready_in, res_data_out [WIDTH], res_id_out [ID_W],
//   res_op_out [3]                        : result side
//   count_out [16] (only with LOGIC_ARB_COUNT_EN): saturating count of
//   consumed results
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. req_ready_out is a one-hot grant that depends on req_valid_in.
// Requesters raise valid without waiting for ready. They hold
// valid/op/a/b stable until accepted.
// The result register is the FSM (EMPTY/FULL). Its state bit drives
// res_valid_out directly.
// Optional feature macro: LOGIC_ARB_COUNT_EN
// WIDTH must be <= 64 (logic_gate_pkg::MAX_W).
// ---------------------------------------------------------------------------
module logic_gate_arbiter
  import logic_gate_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk_in,
  input  logic                     rstn_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [OP_W*NUM_REQ-1:0]  req_op_in,
  input  logic [WIDTH*NUM_REQ-1:0] req_a_in,
  input  logic [WIDTH*NUM_REQ-1:0] req_b_in,
  output logic                     res_valid_out,
  input  logic                     res_ready_in,
  output logic [WIDTH-1:0]         res_data_out,
  output logic [ID_W-1:0]          res_id_out,
  output logic [OP_W-1:0]          res_op_out
`ifdef LOGIC_ARB_COUNT_EN
  ,
  output logic [15:0]              count_out
`endif
);

  logic [0:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [OP_W-1:0]    op_q, op_d;

  logic               can_accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  logic [OP_W-1:0]    sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b, gate_res;

  // Taking a new result in the same cycle as the drain keeps throughput at
  // one result per cycle.
  assign can_accept = (state_q == ST_EMPTY) | res_ready_in;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i   (req_valid_in),
    .ptr_i   (ptr_q),
    .en_i    (can_accept & rstn_in),  // keeps ready low while in reset
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign req_ready_out = grant;
  assign accept        = |grant;

  // One-hot operand mux. OR-ing the slices is exact because only one
  // grant bit can be set.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op = sel_op | req_op_in[OP_W*i +: OP_W];
        sel_a  = sel_a  | req_a_in[WIDTH*i +: WIDTH];
        sel_b  = sel_b  | req_b_in[WIDTH*i +: WIDTH];
      end
    end
  end

  assign gate_res = WIDTH'(logic_op(sel_op, MAX_W'(sel_a), MAX_W'(sel_b)));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    op_d    = op_q;
    if (accept) begin
      state_d = ST_FULL;
      ptr_d   = grant_idx;
      data_d  = gate_res;
      id_d    = grant_idx;
      op_d    = sel_op;
    end else if (state_q == ST_FULL && res_ready_in) begin
      // Drained with nothing to refill: payload keeps its last value.
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      state_q <= ST_EMPTY;
      ptr_q   <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
      data_q  <= '0;
      id_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      op_q    <= op_d;
    end
  end

  assign res_valid_out = (state_q == ST_FULL);
  assign res_data_out  = data_q;
  assign res_id_out    = id_q;
  assign res_op_out    = op_q;

`ifdef LOGIC_ARB_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_FULL && res_ready_in && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign count_out = cnt_q;
`endif

endmodule

// File: tb/tb_logic_gate_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_gate_arbiter
// This bench checks logic_gate_arbiter (NUM_REQ=4, WIDTH=8) against a
// behavioural model.
// - The stimulus side drives inputs just after each rising edge.
// - On the falling edge, the model predicts the grant and pushes the expected
//   {data, id, op} into exp_q.
// - A monitor process pops exp_q and compares whenever it sees
//   res_valid_out & res_ready_in.
// - The gate model uses per-op truth tables. It does not use the package
//   function.
// Define LOGIC_ARB_COUNT_EN to also check count_out.
// ---------------------------------------------------------------------------
module tb_logic_gate_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int EW = W + IW + 3;

  logic           clk_in = 1'b0;
  logic           rstn_in;
  logic [N-1:0]   req_valid_in;
  logic [N-1:0]   req_ready_out;
  logic [3*N-1:0] req_op_in;
  logic [W*N-1:0] req_a_in;
  logic [W*N-1:0] req_b_in;
  logic           res_valid_out;
  logic           res_ready_in;
  logic [W-1:0]   res_data_out;
  logic [IW-1:0]  res_id_out;
  logic [2:0]     res_op_out;
`ifdef LOGIC_ARB_COUNT_EN
  logic [15:0]    count_out;
`endif

  logic_gate_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk_in        (clk_in),
    .rstn_in       (rstn_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_op_in     (req_op_in),
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_data_out  (res_data_out),
    .res_id_out    (res_id_out),
    .res_op_out    (res_op_out)
`ifdef LOGIC_ARB_COUNT_EN
    ,
    .count_out     (count_out)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- bench state ----------------
  int            tests = 0;
  int            fails = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_last;      // payload the register should show when idle
  int            m_ptr;
  bit            m_full;
  int            cons;        // results consumed since reset
  logic [N-1:0]  pend_v;
  logic [2:0]    pend_op [N];
  logic [W-1:0]  pend_a  [N];
  logic [W-1:0]  pend_b  [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each op is a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_gate(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (op)
      3'd0:    tt = 4'b1000;  // AND
      3'd1:    tt = 4'b1110;  // OR
      3'd2:    tt = 4'b0110;  // XOR
      3'd3:    tt = 4'b0011;  // NOT a
      3'd4:    tt = 4'b0101;  // NOT b
      3'd5:    tt = 4'b0111;  // NAND
      3'd6:    tt = 4'b0001;  // NOR
      default: tt = 4'b1001;  // XNOR
    endcase
    for (int j = 0; j < W; j++) r[j] = tt[{a[j], b[j]}];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    pend_v[i]  = 1'b1;
    pend_op[i] = op;
    pend_a[i]  = a;
    pend_b[i]  = b;
  endtask

  task automatic issue_rand(input int i);
    issue(i, 3'($urandom_range(0, 7)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
  endtask

  // One clock cycle. The task is entered just after a rising edge.
  // The model is evaluated on the falling edge.
  task automatic cycle(input bit rr);
    bit           can;
    int           g;
    int           idx;
    logic [W-1:0] d;
    logic [N-1:0] exp_ready;
    req_valid_in = pend_v;
    for (int i = 0; i < N; i++) begin
      req_op_in[3*i +: 3] = pend_op[i];
      req_a_in[W*i +: W]  = pend_a[i];
      req_b_in[W*i +: W]  = pend_b[i];
    end
    res_ready_in = rr;
    @(negedge clk_in);
    if (!rstn_in) begin
      check("ready_in_reset", req_ready_out, 0);
      m_full = 1'b0;
      m_ptr  = N - 1;
      m_last = '0;
      exp_q.delete();
    end else begin
      check("res_valid", res_valid_out, m_full);
      if (m_full && !rr && exp_q.size() > 0)
        check("held_result", {res_data_out, res_id_out, res_op_out}, exp_q[0]);
      if (!m_full)
        check("idle_payload", {res_data_out, res_id_out, res_op_out}, m_last);
      can = !m_full || rr;
      g   = -1;
      if (can) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && pend_v[idx]) g = idx;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready_out, exp_ready);
      if (g >= 0) begin
        d = ref_gate(pend_op[g], pend_a[g], pend_b[g]);
        m_last = {d, 2'(g), pend_op[g]};
        exp_q.push_back(m_last);
        m_ptr     = g;
        m_full    = 1'b1;
        pend_v[g] = 1'b0;
      end else if (m_full && rr) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    cons = 0;
    forever begin
      @(negedge clk_in);
      if (rstn_in !== 1'b1) begin
        cons = 0;
      end else begin
`ifdef LOGIC_ARB_COUNT_EN
        check("count_out", count_out, cons);
`endif
        if (res_valid_out && res_ready_in) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got 0x%0h expected no result at %0t",
                     {res_data_out, res_id_out, res_op_out}, $time);
          end else begin
            e = exp_q.pop_front();
            check("result", {res_data_out, res_id_out, res_op_out}, e);
          end
          if (cons < 65535) cons++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'h0A, 8'hAF, 8'hA5, 8'h55, 8'hF0, 8'hF5, 8'h50, 8'h5A};
    pend_v = '0;
    for (int i = 0; i < N; i++) begin
      pend_op[i] = '0; pend_a[i] = '0; pend_b[i] = '0;
    end
    req_valid_in = '0; req_op_in = '0; req_a_in = '0; req_b_in = '0;
    res_ready_in = 1'b0;
    m_full = 1'b0; m_ptr = N - 1; m_last = '0;
    rstn_in = 1'b0;
    @(posedge clk_in);
    #1;

    // 1: reset held for 2 cycles with every requester valid
    for (int i = 0; i < N; i++) issue_rand(i);
    cycle(1);
    cycle(1);
    rstn_in = 1'b1;
    pend_v  = '0;
    cycle(1);

    // 2: single NAND from requester 0
    issue(0, 3'd5, 8'hF0, 8'h3C);
    cycle(1);
    check("t2_data", res_data_out, 8'hCF);
    check("t2_id", res_id_out, 0);
    check("t2_op", res_op_out, 5);

    // 5: op sweep, one accept per cycle with a same-cycle drain
    for (int op = 0; op < 8; op++) begin
      issue(0, 3'(op), 8'hAA, 8'h0F);
      cycle(1);
      check("t5_sweep", res_data_out, sweep_exp[op]);
    end

    // 3: round-robin with all requesters valid continuously (pointer now 0)
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) if (!pend_v[i]) issue_rand(i);
      cycle(1);
      check("t3_rr_id", res_id_out, (1 + k) % N);
    end
    pend_v = '0;
    cycle(1);
    cycle(1);

    // 4: backpressure for 5 cycles, then release
    issue(1, 3'd2, 8'h5A, 8'hFF);
    cycle(1);
    issue(2, 3'd7, 8'h33, 8'h0F);
    for (int k = 0; k < 5; k++) cycle(0);
    cycle(1);
    check("t4_id_after_release", res_id_out, 2);

    // 6: reset while FULL with a pending result
    for (int i = 0; i < N; i++) issue_rand(i);
    rstn_in = 1'b0;
    cycle(0);
    rstn_in = 1'b1;
    cycle(1);
    check("t6_first_grant", res_id_out, 0);
    for (int k = 0; k < 4; k++) cycle(1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(0, 2) == 0) issue_rand(i);
      cycle($urandom_range(0, 3) != 0);
    end

    // drain
    pend_v = '0;
    for (int k = 0; k < 3; k++) cycle(1);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_valid", res_valid_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "timeout");
  end

endmodule
